// File: rtl/top_level_module.sv
// 2x2 weight-stationary systolic matmul core with column accumulators and a unified buffer.
// Optional ACC_DEBUG_EN: accumulator print_contents reports its two entries.
module top_level_module_pe (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [15:0] i_a,
  input  logic [15:0] i_w,
  input  logic [31:0] i_psum,
  output logic [15:0] o_a,
  output logic [31:0] o_psum
);
  logic [15:0] r_a;
  logic [31:0] r_psum;
  logic [31:0] w_prod;

  assign w_prod = {16'd0, i_a} * {16'd0, i_w};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_psum <= '0;
    end else if (i_en) begin
      r_a    <= i_a;
      r_psum <= i_psum + w_prod;
    end
  end

  assign o_a    = r_a;
  assign o_psum = r_psum;
endmodule

module accumulator (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en0,
  input  logic        i_en1,
  input  logic [31:0] i_din,
  output logic [31:0] o_mem0,
  output logic [31:0] o_mem1
);
  logic [31:0] r_mem0;
  logic [31:0] r_mem1;

  // Add-in: entries keep summing across runs until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else begin
      if (i_en0) r_mem0 <= r_mem0 + i_din;
      if (i_en1) r_mem1 <= r_mem1 + i_din;
    end
  end

  assign o_mem0 = r_mem0;
  assign o_mem1 = r_mem1;

  task automatic print_contents();
`ifdef ACC_DEBUG_EN
    $display("%m: mem[0]=%0d mem[1]=%0d", r_mem0, r_mem1);
`else
`endif
  endtask
endmodule

module top_level_module (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_weight,
  input  logic        valid,
  input  logic [15:0] a_in1,
  input  logic [15:0] a_in2,
  input  logic [15:0] weight1,
  input  logic [15:0] weight2,
  input  logic [15:0] weight3,
  input  logic [15:0] weight4,
  output logic [31:0] acc1_mem_0,
  output logic [31:0] acc1_mem_1,
  output logic [31:0] acc2_mem_0,
  output logic [31:0] acc2_mem_1,
  output logic [31:0] unified_mem_0,
  output logic [31:0] unified_mem_1,
  output logic [31:0] unified_mem_2,
  output logic [31:0] unified_mem_3
);
  logic [15:0] r_w1, r_w2, r_w3, r_w4;
  logic [2:0]  r_cnt;
  logic [31:0] r_uni0, r_uni1, r_uni2, r_uni3;
  logic [15:0] w_a00, w_a01, w_a10, w_a11;
  logic [31:0] w_p00, w_p01, w_p10, w_p11;
  logic        w_cap2, w_cap3, w_cap4, w_cap5;
  logic        w_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w1 <= '0;
      r_w2 <= '0;
      r_w3 <= '0;
      r_w4 <= '0;
    end else if (load_weight) begin
      r_w1 <= weight1;
      r_w2 <= weight2;
      r_w3 <= weight3;
      r_w4 <= weight4;
    end
  end

  top_level_module_pe pe00 (
    .clk(clk), .reset(reset), .i_en(valid),
    .i_a(a_in1), .i_w(r_w1), .i_psum(32'd0),
    .o_a(w_a00), .o_psum(w_p00)
  );
  top_level_module_pe pe01 (
    .clk(clk), .reset(reset), .i_en(valid),
    .i_a(w_a00), .i_w(r_w2), .i_psum(32'd0),
    .o_a(w_a01), .o_psum(w_p01)
  );
  top_level_module_pe pe10 (
    .clk(clk), .reset(reset), .i_en(valid),
    .i_a(a_in2), .i_w(r_w3), .i_psum(w_p00),
    .o_a(w_a10), .o_psum(w_p10)
  );
  top_level_module_pe pe11 (
    .clk(clk), .reset(reset), .i_en(valid),
    .i_a(w_a10), .i_w(r_w4), .i_psum(w_p01),
    .o_a(w_a11), .o_psum(w_p11)
  );

  // Last column's activation and PE01's passthrough leave the grid unused.
  assign w_unused = ^{w_a11, w_a01};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!valid) begin
      r_cnt <= '0;
    end else if (r_cnt != 3'd6) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign w_cap2 = valid && (r_cnt == 3'd2);
  assign w_cap3 = valid && (r_cnt == 3'd3);
  assign w_cap4 = valid && (r_cnt == 3'd4);
  assign w_cap5 = valid && (r_cnt == 3'd5);

  accumulator acc1 (
    .clk(clk), .reset(reset),
    .i_en0(w_cap2), .i_en1(w_cap3), .i_din(w_p10),
    .o_mem0(acc1_mem_0), .o_mem1(acc1_mem_1)
  );
  accumulator acc2 (
    .clk(clk), .reset(reset),
    .i_en0(w_cap3), .i_en1(w_cap4), .i_din(w_p11),
    .o_mem0(acc2_mem_0), .o_mem1(acc2_mem_1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_uni0 <= '0;
      r_uni1 <= '0;
      r_uni2 <= '0;
      r_uni3 <= '0;
    end else if (w_cap5) begin
      r_uni0 <= acc1_mem_0;
      r_uni1 <= acc1_mem_1;
      r_uni2 <= acc2_mem_0;
      r_uni3 <= acc2_mem_1;
    end
  end

  assign unified_mem_0 = r_uni0;
  assign unified_mem_1 = r_uni1;
  assign unified_mem_2 = r_uni2;
  assign unified_mem_3 = r_uni3;
endmodule

// File: tb/tb_top_level_module.sv
// Bench for top_level_module: directed runs plus random streams
// checked against a dataflow-equation model of the systolic grid.
module tb_top_level_module;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load_weight, valid;
  logic [15:0] a_in1, a_in2;
  logic [15:0] weight1, weight2, weight3, weight4;
  logic [31:0] acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1;
  logic [31:0] unified_mem_0, unified_mem_1;
  logic [31:0] unified_mem_2, unified_mem_3;

  top_level_module dut (
    .clk(clk), .reset(reset), .load_weight(load_weight),
    .valid(valid), .a_in1(a_in1), .a_in2(a_in2),
    .weight1(weight1), .weight2(weight2),
    .weight3(weight3), .weight4(weight4),
    .acc1_mem_0(acc1_mem_0), .acc1_mem_1(acc1_mem_1),
    .acc2_mem_0(acc2_mem_0), .acc2_mem_1(acc2_mem_1),
    .unified_mem_0(unified_mem_0), .unified_mem_1(unified_mem_1),
    .unified_mem_2(unified_mem_2), .unified_mem_3(unified_mem_3)
  );

  int checks = 0;
  int errors = 0;

  // Model: history of every valid edge since reset; columns are
  // closed-form sums over that history.
  logic [15:0] h_a1[0:1023];
  logic [15:0] h_a2[0:1023];
  logic [15:0] h_w1[0:1023];
  logic [15:0] h_w2[0:1023];
  logic [15:0] h_w3[0:1023];
  logic [15:0] h_w4[0:1023];
  int          n;
  int          mcnt;
  logic [15:0] mw[4];
  logic [31:0] macc[4];
  logic [31:0] muni[4];
  logic [15:0] s1[7];
  logic [15:0] s2[7];

  function automatic logic [31:0] mul(input logic [15:0] a,
                                      input logic [15:0] b);
    return {16'd0, a} * {16'd0, b};
  endfunction

  function automatic logic [31:0] col0(input int k);
    logic [31:0] s = 32'd0;
    if (k >= 2) s += mul(h_a1[k-2], h_w1[k-2]);
    if (k >= 1) s += mul(h_a2[k-1], h_w3[k-1]);
    return s;
  endfunction

  function automatic logic [31:0] col1(input int k);
    logic [31:0] s = 32'd0;
    if (k >= 3) s += mul(h_a1[k-3], h_w2[k-2]);
    if (k >= 2) s += mul(h_a2[k-2], h_w4[k-1]);
    return s;
  endfunction

  task automatic model_reset();
    n = 0;
    mcnt = 0;
    for (int i = 0; i < 4; i++) begin
      mw[i] = '0;
      macc[i] = '0;
      muni[i] = '0;
    end
  endtask

  task automatic tick();
    logic [31:0] c0, c1;
    if (valid) begin
      c0 = col0(n);
      c1 = col1(n);
      case (mcnt)
        2: macc[0] += c0;
        3: begin
          macc[1] += c0;
          macc[2] += c1;
        end
        4: macc[3] += c1;
        5: muni = macc;
        default: ;
      endcase
      h_a1[n] = a_in1;
      h_a2[n] = a_in2;
      h_w1[n] = mw[0];
      h_w2[n] = mw[1];
      h_w3[n] = mw[2];
      h_w4[n] = mw[3];
      n++;
      if (mcnt < 6) mcnt++;
    end else begin
      mcnt = 0;
    end
    if (load_weight) mw = '{weight1, weight2, weight3, weight4};
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".acc1_0"}, acc1_mem_0, macc[0]);
    chk({tag, ".acc1_1"}, acc1_mem_1, macc[1]);
    chk({tag, ".acc2_0"}, acc2_mem_0, macc[2]);
    chk({tag, ".acc2_1"}, acc2_mem_1, macc[3]);
    chk({tag, ".uni0"}, unified_mem_0, muni[0]);
    chk({tag, ".uni1"}, unified_mem_1, muni[1]);
    chk({tag, ".uni2"}, unified_mem_2, muni[2]);
    chk({tag, ".uni3"}, unified_mem_3, muni[3]);
  endtask

  task automatic chk_const(input string tag, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [31:0] u0,
                           input logic [31:0] u1, input logic [31:0] u2,
                           input logic [31:0] u3);
    chk({tag, ".acc1_0"}, acc1_mem_0, e0);
    chk({tag, ".acc1_1"}, acc1_mem_1, e1);
    chk({tag, ".acc2_0"}, acc2_mem_0, e2);
    chk({tag, ".acc2_1"}, acc2_mem_1, e3);
    chk({tag, ".uni0"}, unified_mem_0, u0);
    chk({tag, ".uni1"}, unified_mem_1, u1);
    chk({tag, ".uni2"}, unified_mem_2, u2);
    chk({tag, ".uni3"}, unified_mem_3, u3);
  endtask

  task automatic do_reset();
    valid = 1'b0;
    load_weight = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("rst_rel");
  endtask

  task automatic load(input logic [15:0] w1, input logic [15:0] w2,
                      input logic [15:0] w3, input logic [15:0] w4);
    weight1 = w1;
    weight2 = w2;
    weight3 = w3;
    weight4 = w4;
    load_weight = 1'b1;
    tick();
    load_weight = 1'b0;
    chk_all("load");
  endtask

  task automatic run_std(input int len);
    for (int i = 0; i < len; i++) begin
      valid = 1'b1;
      a_in1 = s1[i];
      a_in2 = s2[i];
      tick();
      chk_all($sformatf("run_e%0d", i));
    end
    valid = 1'b0;
    a_in1 = '0;
    a_in2 = '0;
  endtask

  task automatic idle(input int len);
    for (int i = 0; i < len; i++) begin
      tick();
      chk_all("idle");
    end
  endtask

  initial begin
    reset = 1'b1;
    load_weight = 1'b0;
    valid = 1'b0;
    a_in1 = '0;
    a_in2 = '0;
    weight1 = '0;
    weight2 = '0;
    weight3 = '0;
    weight4 = '0;
    model_reset();
    s1 = '{16'd11, 16'd12, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    s2 = '{16'd0, 16'd21, 16'd22, 16'd0, 16'd0, 16'd0, 16'd0};
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk_const("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    load(16'd3, 16'd5, 16'd4, 16'd6);
    run_std(7);
    idle(1);
    chk_const("run1", 117, 124, 181, 192, 117, 124, 181, 192);

    run_std(7);
    idle(1);
    chk_const("run2", 234, 248, 362, 384, 234, 248, 362, 384);

    do_reset();
    load(16'd3, 16'd5, 16'd4, 16'd6);
    run_std(3);
    idle(3);
    chk_const("abort", 117, 0, 0, 0, 0, 0, 0, 0);

    do_reset();
    load(16'd3, 16'd5, 16'd4, 16'd6);
    run_std(4);
    reset = 1'b1;
    #1;
    model_reset();
    chk_const("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("midrst_rel");
    load(16'd3, 16'd5, 16'd4, 16'd6);
    run_std(7);
    idle(1);
    chk_const("rerun", 117, 124, 181, 192, 117, 124, 181, 192);

    do_reset();
    load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    s1 = '{16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    s2 = '{16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0};
    run_std(7);
    idle(1);
    chk_const("wrap", 32'hFFFC0002, 32'hFFFC0002, 32'hFFFC0002,
              32'hFFFC0002, 32'hFFFC0002, 32'hFFFC0002,
              32'hFFFC0002, 32'hFFFC0002);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 7) != 0);
      a_in1 = 16'($urandom);
      a_in2 = 16'($urandom);
      load_weight = ($urandom_range(0, 15) == 0);
      weight1 = 16'($urandom);
      weight2 = 16'($urandom);
      weight3 = 16'($urandom);
      weight4 = 16'($urandom);
      tick();
      chk_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
